ifft_sdf_stage: RTL
===================

# ifft_sdf_stage

Single radix-2 decimation-in-frequency IFFT stage in single-path delay-feedback (SDF) form, for the OFDM transmit path. It is the inverse-direction counterpart of the receive-side FFT butterfly. The stage accepts one complex sample per valid cycle in natural order and produces the stage output stream in the same order: N/2 sums, then N/2 rotated differences. The stage scales by 1/2, so a cascade of log2(N) stages yields the 1/N IFFT normalisation. Stages are cascaded with STAGE_N = N, N/2, …, 2.

## Interface
- STAGE_N, 8: butterfly span; a power of 2 and ≥ 2. The delay line is STAGE_N/2 deep.
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_sop are valid this cycle. There is no backpressure.
- in_sop  input  1  first sample of a frame; qualified by in_valid.
- in_data  input  $bits(complex_product_t)  input sample; fields .r and .i are signed.
- out_valid  output  1  out_data is valid; registered.
- out_sop  output  1  marks output X0 of a frame; registered.
- out_data  output  $bits(complex_product_t)  output sample; registered.
- sync_err  output  1  one-cycle pulse when in_sop arrives with cnt ≠ 0.

## Operation
- **State.** The stage holds:
  - cnt: log2(STAGE_N) bits; advances only on in_valid and wraps at STAGE_N.
  - primed: 1 bit.
  - delay: a FIFO of STAGE_N/2 complex entries, shifted only on in_valid.
- **Phase.** phase = cnt MSB. Index k = cnt mod STAGE_N/2.
- **Phase 0 (fill).** On each valid cycle:
  - Output the delay head, which is a Y from the previous frame.
  - Assert out_valid only if primed = 1.
  - Push in_data into the delay line.
- **Phase 1 (butterfly).** On each valid cycle:
  - A = delay head, B = in_data.
  - Output X = (A + B) >>> 1 per field, with out_valid = 1.
  - Assert out_sop when k = 0.
  - Push Y = rot((A − B) >>> 1, k).
  - When k = STAGE_N/2 − 1, set primed = 1.
- **Rotation.** rot(d, k) uses twiddle W^k = wr + j·wi, with wr = round(256·cos(2πk/STAGE_N)) and wi = round(256·sin(2πk/STAGE_N)).
  - Twiddles are Q8 (256 = 1.0). The sign is positive because this is the inverse transform. Hold them in a constant ROM indexed by k.
  - r = (d.r·wr − d.i·wi) >>> 8
  - i = (d.r·wi + d.i·wr) >>> 8
  - Products and sums use full width. Shifts are arithmetic (round toward −∞).
  - Saturate r and i to the field range of complex_product_t. Sums before the >>>1 use one extra bit, so X never overflows.
- **Sync.** When in_valid && in_sop:
  - If cnt = 0: proceed normally.
  - If cnt ≠ 0: treat the sample as cnt = 0 (phase 0, k = 0), pulse sync_err, and clear primed. The partial frame and pending Y values are discarded, and no output is produced in this phase 0. cnt continues from 1.
- **Non-valid cycles.** out_valid = 0 and out_sop = 0. State and out_data hold.
- **Reset.** Sets cnt = 0, primed = 0, out_valid = 0, out_sop = 0, sync_err = 0, out_data = 0. The delay line is zeroed.
  - Reset mid-frame drops all in-flight data. The first frame after reset produces no output during its phase 0.

## Timing
- Outputs are registered. The output for an input accepted in cycle t appears in cycle t+1.
- X_k appears 1 cycle after input sample N/2+k.
- Y_k appears 1 cycle after sample k of the next frame. Steady-state throughput is 1 sample/valid cycle with no bubbles.
- The last frame's Y values are emitted only when the next frame's phase-0 samples arrive. To drain, feed STAGE_N/2 zero samples.
- in_valid gaps stretch the timing uniformly; no data is lost or duplicated.
- Reset takes priority over in_valid in the same cycle.

## Test plan
- **Reset and priming.** STAGE_N = 2. Assert reset for 2 cycles, then frame [256, 512], then frame [0, 0] (imag 0).
  - Expected outputs, in order: X0 = 384 (out_sop = 1), then Y0 = −128.
  - There is no out_valid during the first phase-0 cycle.
- **Twiddle rotation.** STAGE_N = 8. Frame A = 1024 for k = 0..3, B = 0 (imag 0), then a zero frame.
  - X = 512 ×4.
  - Y = 512+j0, 362+j362, 0+j512, −362+j362.
- **Gapped input.** Repeat the rotation test with in_valid deasserted every other cycle.
  - Output values and order are identical; out_valid is never asserted on a cycle following a non-valid input cycle.
- **Saturation.** STAGE_N = 8. A = maxpos − j·maxpos, B = −A, at k = 1.
  - Y.r saturates to the field maximum and Y.i = 0 (per the rotation formula); there is no wrap.
- **Resync.** in_sop at cnt = 5 (STAGE_N = 8).
  - sync_err pulses once, primed clears, and no out_valid occurs in the following phase 0.
  - The next frame's outputs are then correct.
- **Mid-frame reset.** Reset at cnt = 6.
  - All outputs go to 0 the next cycle.
  - Subsequent frames behave exactly as after power-on reset.

Source files
------------

// File: rtl/ifft_sdf_stage.sv
// One radix-2 decimation-in-frequency IFFT stage in single-path delay-feedback form.
// Each stage halves its output; Q8 twiddles carry the positive (inverse) sign.
package ifft_pkg;
  localparam int FW = 16;
  typedef struct packed {
    logic signed [FW-1:0] r;
    logic signed [FW-1:0] i;
  } complex_product_t;
endpackage

module ifft_sdf_stage
  import ifft_pkg::*;
#(
  parameter int STAGE_N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sop,
  input  complex_product_t in_data,
  output logic             out_valid,
  output logic             out_sop,
  output complex_product_t out_data,
  output logic             sync_err
);

  localparam int HALF = STAGE_N / 2;
  localparam int CW   = $clog2(STAGE_N);
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int STEP = 64 / STAGE_N;
  localparam int AW   = 2 * FW + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (FW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (FW - 1)));

  // Quarter wave of round(256*sin(2*pi*m/64)); the ROM covers STAGE_N up to 64.
  function automatic int qSin(input int m);
    case (m)
      0: return 0;     1: return 25;    2: return 50;    3: return 74;
      4: return 98;    5: return 121;   6: return 142;   7: return 162;
      8: return 181;   9: return 198;   10: return 213;  11: return 226;
      12: return 237;  13: return 245;  14: return 251;  15: return 255;
      default: return 256;
    endcase
  endfunction

  function automatic int sinTab(input int m);
    int q;
    int o;
    q = m / 16;
    o = m % 16;
    case (q)
      0: return qSin(o);
      1: return qSin(16 - o);
      2: return -qSin(o);
      default: return -qSin(16 - o);
    endcase
  endfunction

  function automatic logic signed [FW-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[FW-1:0];
    if (v < SAT_MIN) return SAT_MIN[FW-1:0];
    return v[FW-1:0];
  endfunction

  logic [CW-1:0]        r_cnt;
  logic                 r_primed;
  complex_product_t     r_delay [HALF];
  logic                 r_out_valid;
  logic                 r_out_sop;
  logic                 r_sync_err;
  complex_product_t     r_out_data;

  logic                 w_resync;
  logic                 w_phase;
  logic [CW-1:0]        w_cnt;
  logic [KW-1:0]        w_k;
  complex_product_t     w_head;
  complex_product_t     w_x;
  complex_product_t     w_y;
  complex_product_t     w_push;
  logic signed [FW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [FW-1:0] w_d_r, w_d_i, w_wr, w_wi;
  logic signed [AW-1:0] w_acc_r, w_acc_i;
  logic signed [FW-1:0] w_twr [2**KW];
  logic signed [FW-1:0] w_twi [2**KW];

  for (genvar g = 0; g < 2**KW; g++) begin : g_rom
    localparam int WR = sinTab((g * STEP + 16) % 64);
    localparam int WI = sinTab(g * STEP);
    assign w_twr[g] = FW'(WR);
    assign w_twi[g] = FW'(WI);
  end

  // A misplaced sop restarts the frame as if cnt were already 0.
  always_comb begin
    w_resync = in_valid && in_sop && (r_cnt != '0);
    w_cnt    = w_resync ? '0 : r_cnt;
    w_phase  = w_cnt[CW-1];
    w_k      = KW'(int'(w_cnt) % HALF);
    w_head   = r_delay[HALF-1];

    w_sum_r  = (FW+1)'(w_head.r) + (FW+1)'(in_data.r);
    w_sum_i  = (FW+1)'(w_head.i) + (FW+1)'(in_data.i);
    w_dif_r  = (FW+1)'(w_head.r) - (FW+1)'(in_data.r);
    w_dif_i  = (FW+1)'(w_head.i) - (FW+1)'(in_data.i);
    w_x.r    = w_sum_r[FW:1];
    w_x.i    = w_sum_i[FW:1];
    w_d_r    = w_dif_r[FW:1];
    w_d_i    = w_dif_i[FW:1];

    w_wr     = w_twr[w_k];
    w_wi     = w_twi[w_k];
    w_acc_r  = AW'(w_d_r) * AW'(w_wr) - AW'(w_d_i) * AW'(w_wi);
    w_acc_i  = AW'(w_d_r) * AW'(w_wi) + AW'(w_d_i) * AW'(w_wr);
    w_y.r    = sat(w_acc_r >>> 8);
    w_y.i    = sat(w_acc_i >>> 8);

    w_push   = w_phase ? w_y : in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_sync_err  <= 1'b0;
      r_out_data  <= '0;
      for (int j = 0; j < HALF; j++) r_delay[j] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_sync_err  <= 1'b0;
      if (in_valid) begin
        r_cnt      <= CW'(w_cnt + 1'b1);
        r_sync_err <= w_resync;
        r_delay[0] <= w_push;
        for (int j = 1; j < HALF; j++) r_delay[j] <= r_delay[j-1];
        if (!w_phase) begin
          r_out_data  <= w_head;
          r_out_valid <= r_primed && !w_resync;
          if (w_resync) r_primed <= 1'b0;
        end else begin
          r_out_data  <= w_x;
          r_out_valid <= 1'b1;
          r_out_sop   <= (w_k == '0);
          if (int'(w_k) == HALF - 1) r_primed <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_data  = r_out_data;
  assign sync_err  = r_sync_err;

endmodule
